// File: rtl/sdr_host_req_pkg.sv
// Shared constants for the SDRAM host-side requester: host FSM state
// encodings, default timing values and the refresh backlog limit.
package sdr_host_req_pkg;

  // Default timing at 100 MHz
  localparam int DEF_NUM_CLK_100US = 10000;
  localparam int DEF_REF_PERIOD    = 1560;
  localparam int DEF_CNT_W         = 16;

  // Refresh backlog register: up to 7 outstanding refreshes
  localparam int               PEND_W   = 3;
  localparam logic [PEND_W-1:0] PEND_MAX = 3'd7;

  // Host FSM state encodings
  localparam logic [1:0] H_WAIT_INIT = 2'd0;
  localparam logic [1:0] H_IDLE      = 2'd1;
  localparam logic [1:0] H_STROBE    = 2'd2;
  localparam logic [1:0] H_WAIT_END  = 2'd3;

  // Statistics counter width
  localparam int STAT_W = 16;

  // Saturating increment for the statistics counters
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/sdr_host_req_ref_timer.sv
// sdr_ref_timer: periodic refresh tick generator with a pending-refresh
// backlog retired by rising edges of the controller's refresh acknowledge.
// Optional macro SDR_HOST_STATS_EN exposes the ack edge for statistics.
module sdr_ref_timer
  import sdr_host_req_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_init_done,
  input  logic              i_ref_ack,
  output logic              o_ref_req,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_ref_overrun
`ifdef SDR_HOST_STATS_EN
  ,
  output logic              o_ack_rise
`endif
);

  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_PERIOD - 1);

  logic [CNT_W-1:0]  r_ref_cnt;
  logic [PEND_W-1:0] r_pending;
  logic              r_ack_d;
  logic              r_ref_req;
  logic              r_overrun;

  logic              w_tick;
  logic              w_ack_rise;
  logic [PEND_W-1:0] w_pend_next;
  logic              w_ovr_set;

  // Tick, ack edge and next backlog value; all frozen while init_done is low
  always_comb begin
    w_tick      = i_init_done && (r_ref_cnt == REF_LAST);
    w_ack_rise  = i_ref_ack && !r_ack_d;
    w_pend_next = r_pending;
    w_ovr_set   = 1'b0;
    if (i_init_done) begin
      if (w_tick && !w_ack_rise) begin
        if (r_pending == PEND_MAX) begin
          w_ovr_set = 1'b1;
        end else begin
          w_pend_next = r_pending + PEND_W'(1);
        end
      end else if (!w_tick && w_ack_rise && (r_pending != '0)) begin
        w_pend_next = r_pending - PEND_W'(1);
      end
    end
  end

  // Refresh period counter, cleared whenever the controller is not initialised
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ref_cnt <= '0;
    end else if (!i_init_done || w_tick) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + CNT_W'(1);
    end
  end

  // Backlog, registered request flag (tracks the new backlog) and sticky overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_ack_d   <= 1'b0;
      r_ref_req <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_ack_d   <= i_ref_ack;
      r_pending <= w_pend_next;
      r_ref_req <= (w_pend_next != '0);
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_ref_req     = r_ref_req;
  assign o_pending     = r_pending;
  assign o_ref_overrun = r_overrun;
`ifdef SDR_HOST_STATS_EN
  assign o_ack_rise    = w_ack_rise;
`endif

endmodule

// File: rtl/sdr_host_req.sv
// sdr_host_req: host-side initiator for the SDRAM command controller.
// Power-up qualifier, refresh requests, and a valid/ready request stream
// converted into the active-low address strobe plus read/write select.
// Optional macro SDR_HOST_STATS_EN adds saturating stat_rd/stat_wr/stat_ref.
module sdr_host_req
  import sdr_host_req_pkg::*;
#(
  parameter int NUM_CLK_100US = DEF_NUM_CLK_100US,
  parameter int REF_PERIOD    = DEF_REF_PERIOD,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_rd,
  output logic req_ready,
  output logic xfer_done,
  output logic busy,
  input  logic init_done,
  input  logic cy_end,
  input  logic ref_ack,
  output logic delay_100us,
  output logic ref_req,
  output logic addrs,
  output logic rd_wr,
  output logic ref_overrun
`ifdef SDR_HOST_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_rd,
  output logic [STAT_W-1:0] stat_wr,
  output logic [STAT_W-1:0] stat_ref
`endif
);

  localparam logic [CNT_W-1:0] PU_LAST = CNT_W'(NUM_CLK_100US - 1);

  logic [CNT_W-1:0]  r_pu_cnt;
  logic              r_delay_100us;
  logic [1:0]        r_state;
  logic              r_addrs;
  logic              r_rd_wr;
  logic              r_busy;
  logic              r_xfer_done;
  logic [PEND_W-1:0] w_ref_pending;
  logic              w_req_ready;
`ifdef SDR_HOST_STATS_EN
  logic              w_ack_rise;
  logic [STAT_W-1:0] r_stat_rd;
  logic [STAT_W-1:0] r_stat_wr;
  logic [STAT_W-1:0] r_stat_ref;
`endif

  sdr_ref_timer #(
    .REF_PERIOD (REF_PERIOD),
    .CNT_W      (CNT_W)
  ) u_ref_timer (
    .clk           (clk),
    .reset         (reset),
    .i_init_done   (init_done),
    .i_ref_ack     (ref_ack),
    .o_ref_req     (ref_req),
    .o_pending     (w_ref_pending),
    .o_ref_overrun (ref_overrun)
`ifdef SDR_HOST_STATS_EN
    ,
    .o_ack_rise    (w_ack_rise)
`endif
  );

  // Power-up wait: count once from reset release, then latch delay_100us
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pu_cnt      <= '0;
      r_delay_100us <= 1'b0;
    end else if (!r_delay_100us) begin
      if (r_pu_cnt == PU_LAST) begin
        r_delay_100us <= 1'b1;
      end else begin
        r_pu_cnt <= r_pu_cnt + CNT_W'(1);
      end
    end
  end

  // New accesses only when idle and no refresh is owed to the controller
  assign w_req_ready = (r_state == H_IDLE) && init_done && (w_ref_pending == '0);

  // Host FSM: strobe held until the controller starts the access, then wait for cy_end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= H_WAIT_INIT;
      r_addrs     <= 1'b1;
      r_rd_wr     <= 1'b1;
      r_busy      <= 1'b0;
      r_xfer_done <= 1'b0;
    end else begin
      r_xfer_done <= 1'b0;
      if (!init_done) begin
        r_state <= H_WAIT_INIT;
        r_addrs <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          H_WAIT_INIT: r_state <= H_IDLE;
          H_IDLE: begin
            if (req_valid && w_req_ready) begin
              r_rd_wr <= req_rd;
              r_addrs <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= H_STROBE;
            end
          end
          H_STROBE: begin
            // cy_end stays high while the controller serves a refresh first
            if (!cy_end) begin
              r_addrs <= 1'b1;
              r_state <= H_WAIT_END;
            end
          end
          H_WAIT_END: begin
            if (cy_end) begin
              r_xfer_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= H_IDLE;
            end
          end
          default: r_state <= H_WAIT_INIT;
        endcase
      end
    end
  end

`ifdef SDR_HOST_STATS_EN
  // Saturating completion and refresh-ack counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_rd  <= '0;
      r_stat_wr  <= '0;
      r_stat_ref <= '0;
    end else begin
      if (r_xfer_done && r_rd_wr) begin
        r_stat_rd <= sat_inc(r_stat_rd);
      end
      if (r_xfer_done && !r_rd_wr) begin
        r_stat_wr <= sat_inc(r_stat_wr);
      end
      if (w_ack_rise) begin
        r_stat_ref <= sat_inc(r_stat_ref);
      end
    end
  end

  assign stat_rd  = r_stat_rd;
  assign stat_wr  = r_stat_wr;
  assign stat_ref = r_stat_ref;
`endif

  assign req_ready   = w_req_ready;
  assign xfer_done   = r_xfer_done;
  assign busy        = r_busy;
  assign delay_100us = r_delay_100us;
  assign addrs       = r_addrs;
  assign rd_wr       = r_rd_wr;

endmodule

// File: tb/tb_sdr_host_req.sv
// Bench for sdr_host_req with short timing (20-clock power-up, 50-clock refresh).
module tb_sdr_host_req;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic req_rd = 1'b0;
  logic req_ready;
  logic xfer_done;
  logic busy;
  logic init_done = 1'b0;
  logic cy_end = 1'b1;
  logic ref_ack = 1'b0;
  logic delay_100us;
  logic ref_req;
  logic addrs;
  logic rd_wr;
  logic ref_overrun;

  int total = 0;
  int bad = 0;

  // Expected rd_wr of each accepted access, consumed when xfer_done pulses
  logic sb[$];

  typedef struct {
    logic       init_done;
    logic       valid;
    logic       rd;
    logic       cy_end;
    logic       push;
    logic [3:0] exp;   // {addrs, rd_wr, busy, req_ready}
  } vec_t;

  vec_t vecs[11];

  sdr_host_req #(
    .NUM_CLK_100US (20),
    .REF_PERIOD    (50),
    .CNT_W         (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_ready   (req_ready),
    .xfer_done   (xfer_done),
    .busy        (busy),
    .init_done   (init_done),
    .cy_end      (cy_end),
    .ref_ack     (ref_ack),
    .delay_100us (delay_100us),
    .ref_req     (ref_req),
    .addrs       (addrs),
    .rd_wr       (rd_wr),
    .ref_overrun (ref_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every xfer_done pulse must match an accepted access
  always @(negedge clk) begin
    if (reset && xfer_done) begin
      if (sb.size() == 0) begin
        chk("xfer_unexpected", 32'(xfer_done), 32'd0);
      end else begin
        logic exp_rw;
        exp_rw = sb.pop_front();
        chk("xfer_rd_wr", 32'(rd_wr), 32'(exp_rw));
        $display("xfer_done rd_wr=%0b", rd_wr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_p;

    // Read access: strobe, cy_end low 2 cycles after strobe, high 6 cycles later
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0110};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101};

    // Reset values
    step();
    step();
    chk("reset_vals", 32'({addrs, rd_wr, req_ready, xfer_done, busy, delay_100us, ref_req, ref_overrun}), 32'hC0);
    chk("reset_pending", 32'(dut.w_ref_pending), 32'd0);
    $display("reset check addrs=%0b rd_wr=%0b", addrs, rd_wr);

    // Power-up qualifier
    reset = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      chk("pu_delay", 32'(delay_100us), 32'(k >= 20));
      if (k == 19) begin
        chk("pu_idle_outs", 32'({addrs, busy, ref_req, req_ready}), 32'b1000);
      end
      $display("powerup cycle=%0d delay_100us=%0b", k, delay_100us);
    end

    // Table-driven read access
    for (int i = 0; i < 11; i++) begin
      init_done = vecs[i].init_done;
      req_valid = vecs[i].valid;
      req_rd    = vecs[i].rd;
      cy_end    = vecs[i].cy_end;
      if (vecs[i].push) sb.push_back(vecs[i].rd);
      step();
      chk($sformatf("read_vec%0d", i), 32'({addrs, rd_wr, busy, req_ready}), 32'(vecs[i].exp));
      $display("vec %0d addrs=%0b rd_wr=%0b busy=%0b ready=%0b", i, addrs, rd_wr, busy, req_ready);
    end
    req_valid = 1'b0;

    // Refresh backlog and overrun with no acknowledge
    init_done = 1'b0;
    step();
    init_done = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      step();
      if ((k % 50 == 0) || (k % 50 == 49)) begin
        exp_p = (k / 50 > 7) ? 3'd7 : 3'(k / 50);
        chk($sformatf("pending_k%0d", k), 32'(dut.w_ref_pending), 32'(exp_p));
        chk($sformatf("ref_req_k%0d", k), 32'(ref_req), 32'(k >= 50));
        chk($sformatf("overrun_k%0d", k), 32'(ref_overrun), 32'(k >= 400));
        $display("refresh k=%0d ref_req=%0b overrun=%0b", k, ref_req, ref_overrun);
      end
    end
    chk("ready_blocked", 32'(req_ready), 32'd0);

    // Two-cycle ack counts once
    ref_ack = 1'b1;
    step();
    step();
    ref_ack = 1'b0;
    chk("ack_2cyc", 32'(dut.w_ref_pending), 32'd6);
    $display("ack 2-cycle pending=%0d", dut.w_ref_pending);
    for (int k = 403; k <= 449; k++) step();

    // Tick coinciding with an ack rising edge
    ref_ack = 1'b1;
    step();
    chk("tick_ack_pend", 32'(dut.w_ref_pending), 32'd6);
    chk("tick_ack_req", 32'(ref_req), 32'd1);
    $display("tick+ack pending=%0d", dut.w_ref_pending);
    ref_ack = 1'b0;
    step();

    // Drain the backlog one ack at a time
    for (int i = 0; i < 6; i++) begin
      ref_ack = 1'b1;
      step();
      ref_ack = 1'b0;
      step();
      chk("drain", 32'(dut.w_ref_pending), 32'(5 - i));
      $display("drain pending=%0d", dut.w_ref_pending);
    end
    chk("drain_req", 32'(ref_req), 32'd0);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    step();
    chk("ack_at_zero", 32'(dut.w_ref_pending), 32'd0);
    chk("overrun_sticky", 32'(ref_overrun), 32'd1);
    chk("ready_again", 32'(req_ready), 32'd1);

    // Write strobe held while the controller serves a refresh
    req_valid = 1'b1;
    req_rd    = 1'b0;
    cy_end    = 1'b1;
    sb.push_back(1'b0);
    step();
    req_valid = 1'b0;
    chk("wr_accept", 32'({addrs, rd_wr, busy}), 32'b001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wr_hold", 32'({addrs, rd_wr, busy}), 32'b001);
      $display("write hold addrs=%0b rd_wr=%0b", addrs, rd_wr);
    end
    cy_end = 1'b0;
    step();
    chk("wr_started", 32'({addrs, rd_wr, busy}), 32'b101);
    cy_end = 1'b1;
    step();
    chk("wr_done", 32'({addrs, rd_wr, busy, xfer_done}), 32'b1001);
    step();
    chk("wr_pulse_end", 32'(xfer_done), 32'd0);

    // Reset asserted in the middle of H_WAIT_END
    req_valid = 1'b1;
    req_rd    = 1'b1;
    step();
    req_valid = 1'b0;
    cy_end    = 1'b0;
    step();
    chk("abort_in_wait", 32'({addrs, busy}), 32'b11);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_async", 32'({addrs, busy, delay_100us, xfer_done}), 32'b1000);
    $display("async reset addrs=%0b busy=%0b delay=%0b", addrs, busy, delay_100us);
    cy_end = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    step();
    chk("after_reset", 32'({busy, xfer_done, delay_100us}), 32'b000);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
